// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the multi-stage reset sequencer.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned     SYNC_STAGES = 2;
    localparam longint unsigned NS_PER_S    = 64'd1_000_000_000;

    // Ceiling ns-to-cycles conversion in 64-bit math; never returns less than 1.
    function automatic int unsigned ns_to_cycles(input longint unsigned ns,
                                                 input longint unsigned hz);
        longint unsigned cyc;
        cyc = (ns * hz + NS_PER_S - 64'd1) / NS_PER_S;
        return (cyc == 64'd0) ? 32'd1 : 32'(cyc);
    endfunction

endpackage

// File: rtl/reset_sequencer_trigger_conditioner.sv
// Two-flop synchroniser for the restart request, with an optional debounce
// stage enabled by RESET_SEQUENCER_DEBOUNCE_EN.
module reset_sequencer_trigger_conditioner
    import reset_sequencer_pkg::*;
#(
    parameter int unsigned CLOCK_HZ    = 48000000,
    parameter int unsigned DEBOUNCE_NS = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic trigger_in,
    output logic trig_s
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], trigger_in};
        end
    end

`ifdef RESET_SEQUENCER_DEBOUNCE_EN
    localparam int unsigned DB_CYCLES = ns_to_cycles(64'(DEBOUNCE_NS), 64'(CLOCK_HZ));
    localparam int unsigned DB_W      = $clog2(DB_CYCLES + 1);

    logic [DB_W-1:0] db_cnt_q;
    logic            trig_q;

    // Output follows the synchronised level only after it has differed for DB_CYCLES.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt_q <= '0;
            trig_q   <= 1'b0;
        end else if (sync_q[SYNC_STAGES-1] == trig_q) begin
            db_cnt_q <= '0;
        end else if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
            db_cnt_q <= '0;
            trig_q   <= sync_q[SYNC_STAGES-1];
        end else begin
            db_cnt_q <= db_cnt_q + DB_W'(1);
        end
    end

    assign trig_s = trig_q;
`else
    assign trig_s = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/reset_sequencer.sv
// Multi-stage reset generator: releases NUM_STAGES resets in order, restartable
// by trigger_in. Optional trigger debounce via RESET_SEQUENCER_DEBOUNCE_EN.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int unsigned CLOCK_HZ      = 48000000,
    parameter int unsigned NUM_STAGES    = 3,
    parameter int unsigned STAGE_TIME_NS = 255,
    parameter int unsigned DEBOUNCE_NS   = 1000000,
    localparam int unsigned STAGE_CYCLES = ns_to_cycles(64'(STAGE_TIME_NS), 64'(CLOCK_HZ)),
    localparam int unsigned CNT_W        = $clog2(STAGE_CYCLES + 1),
    localparam int unsigned STAGE_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  trigger_in,
    output logic [NUM_STAGES-1:0] reset_out,
    output logic                  busy,
    output logic [STAGE_W-1:0]    stage_out,
    output logic [CNT_W-1:0]      counter_out,
    output logic                  counter_non_zero
);

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(STAGE_CYCLES - 1);

    logic                  trig_s;
    state_t                state_q,  state_d;
    logic [NUM_STAGES-1:0] rst_q,    rst_d;
    logic [STAGE_W-1:0]    stage_q,  stage_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic                  busy_q;
    logic                  nz_q;

    reset_sequencer_trigger_conditioner #(
        .CLOCK_HZ    (CLOCK_HZ),
        .DEBOUNCE_NS (DEBOUNCE_NS)
    ) u_trig (
        .clk        (clk),
        .reset      (reset),
        .trigger_in (trigger_in),
        .trig_s     (trig_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= COUNT;
            rst_q   <= '1;
            stage_q <= '0;
            cnt_q   <= CNT_RELOAD;
            busy_q  <= 1'b1;
            nz_q    <= (CNT_RELOAD != '0);
        end else begin
            state_q <= state_d;
            rst_q   <= rst_d;
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
            busy_q  <= |rst_d;
            nz_q    <= (cnt_d != '0);
        end
    end

    // Trigger overrides every state, including a release due on the same edge.
    always_comb begin
        state_d = state_q;
        rst_d   = rst_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;

        if (trig_s) begin
            state_d = HOLD;
            rst_d   = '1;
            stage_d = '0;
            cnt_d   = CNT_RELOAD;
        end else begin
            unique case (state_q)
                HOLD: begin
                    state_d = COUNT;
                    rst_d   = '1;
                    stage_d = '0;
                    cnt_d   = CNT_RELOAD;
                end
                COUNT: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
                            if (stage_q == STAGE_W'(i)) begin
                                rst_d[i] = 1'b0;
                            end
                        end
                        stage_d = stage_q + STAGE_W'(1);
                        if (stage_q == STAGE_W'(NUM_STAGES - 1)) begin
                            state_d = DONE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = CNT_RELOAD;
                        end
                    end
                end
                DONE: begin
                    rst_d = '0;
                    cnt_d = '0;
                end
                default: begin
                    state_d = COUNT;
                    rst_d   = '1;
                    stage_d = '0;
                    cnt_d   = CNT_RELOAD;
                end
            endcase
        end
    end

    assign reset_out        = rst_q;
    assign busy             = busy_q;
    assign stage_out        = stage_q;
    assign counter_out      = cnt_q;
    assign counter_non_zero = nz_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench: default 3-stage sequencer plus a 4-stage, 1-cycle-per-stage instance.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       trigger_in = 1'b0;

    logic [2:0] r_out;
    logic       busy;
    logic [1:0] stage;
    logic [3:0] cnt;
    logic       nz;

    logic [3:0] r4_out;
    logic       busy4;
    logic [2:0] stage4;
    logic [0:0] cnt4;
    logic       nz4;

    int n_checks = 0;
    int n_fail   = 0;
    int cur_edge = 0;

    always #10 clk = ~clk;

    reset_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .trigger_in       (trigger_in),
        .reset_out        (r_out),
        .busy             (busy),
        .stage_out        (stage),
        .counter_out      (cnt),
        .counter_non_zero (nz)
    );

    reset_sequencer #(
        .NUM_STAGES    (4),
        .STAGE_TIME_NS (10)
    ) dut4 (
        .clk              (clk),
        .reset            (reset),
        .trigger_in       (1'b0),
        .reset_out        (r4_out),
        .busy             (busy4),
        .stage_out        (stage4),
        .counter_out      (cnt4),
        .counter_non_zero (nz4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cur_edge);
        end
    endtask

    // Advance to 2 ns after rising edge n (counted from reset release).
    task automatic goto(input int n);
        repeat (n - cur_edge) @(posedge clk);
        cur_edge = n;
        #2;
    endtask

    task automatic check_main(input string tag, input logic [2:0] r, input logic [1:0] s,
                              input logic [3:0] c, input logic b);
        check({tag, ".reset_out"}, 32'(r_out), 32'(r));
        check({tag, ".stage"},     32'(stage), 32'(s));
        check({tag, ".counter"},   32'(cnt),   32'(c));
        check({tag, ".busy"},      32'(busy),  32'(b));
        check({tag, ".nz"},        32'(nz),    32'(c != 4'd0));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check_main("rst", 3'b111, 2'd0, 4'd12, 1'b1);
        check("rst4.reset_out", 32'(r4_out), 32'hF);
        check("rst4.nz",        32'(nz4),    32'd0);
        reset = 1'b0;
        cur_edge = 0;

        // 4-stage, 1-cycle instance releases one stage per edge.
        goto(1);
        check_main("e1", 3'b111, 2'd0, 4'd11, 1'b1);
        check("e1.r4", 32'(r4_out), 32'hE);
        check("e1.nz4", 32'(nz4), 32'd0);
        goto(2);
        check("e2.r4", 32'(r4_out), 32'hC);
        goto(3);
        check("e3.r4", 32'(r4_out), 32'h8);
        check("e3.busy4", 32'(busy4), 32'd1);
        goto(4);
        check("e4.r4", 32'(r4_out), 32'h0);
        check("e4.busy4", 32'(busy4), 32'd0);
        check("e4.stage4", 32'(stage4), 32'd4);
        check("e4.cnt4", 32'(cnt4), 32'd0);

        // Power-on release at edges 13, 26, 39.
        goto(12);
        check_main("e12", 3'b111, 2'd0, 4'd0, 1'b1);
        goto(13);
        check_main("e13", 3'b110, 2'd1, 4'd12, 1'b1);
        goto(25);
        check_main("e25", 3'b110, 2'd1, 4'd0, 1'b1);
        goto(26);
        check_main("e26", 3'b100, 2'd2, 4'd12, 1'b1);
        goto(38);
        check_main("e38", 3'b100, 2'd2, 4'd0, 1'b1);
        goto(39);
        check_main("e39", 3'b000, 2'd3, 4'd0, 1'b0);
        goto(60);
        check_main("done", 3'b000, 2'd3, 4'd0, 1'b0);

        // One-cycle trigger pulse sampled at edge 100.
        goto(99);
        trigger_in = 1'b1;
        goto(100);
        trigger_in = 1'b0;
        goto(101);
        check_main("t101", 3'b000, 2'd3, 4'd0, 1'b0);
        goto(102);
        check_main("t102", 3'b111, 2'd0, 4'd12, 1'b1);
        goto(103);
        check_main("t103", 3'b111, 2'd0, 4'd12, 1'b1);
        goto(104);
        check_main("t104", 3'b111, 2'd0, 4'd11, 1'b1);
        goto(115);
        check("t115.reset_out", 32'(r_out), 32'h7);
        goto(116);
        check_main("t116", 3'b110, 2'd1, 4'd12, 1'b1);
        goto(129);
        check_main("t129", 3'b100, 2'd2, 4'd12, 1'b1);
        goto(142);
        check_main("t142", 3'b000, 2'd3, 4'd0, 1'b0);

        // Restart, then hold trigger for 50 cycles while stage 1 is counting.
        goto(149);
        trigger_in = 1'b1;
        goto(150);
        trigger_in = 1'b0;
        goto(166);
        check_main("h166", 3'b110, 2'd1, 4'd12, 1'b1);
        goto(170);
        check_main("h170", 3'b110, 2'd1, 4'd8, 1'b1);
        trigger_in = 1'b1;
        goto(172);
        check("h172.reset_out", 32'(r_out), 32'h6);
        goto(173);
        check_main("h173", 3'b111, 2'd0, 4'd12, 1'b1);
        goto(200);
        check_main("h200", 3'b111, 2'd0, 4'd12, 1'b1);
        goto(220);
        trigger_in = 1'b0;
        goto(222);
        check_main("h222", 3'b111, 2'd0, 4'd12, 1'b1);
        goto(223);
        check_main("h223", 3'b111, 2'd0, 4'd12, 1'b1);
        goto(224);
        check_main("h224", 3'b111, 2'd0, 4'd11, 1'b1);
        goto(235);
        check("h235.reset_out", 32'(r_out), 32'h7);
        goto(236);
        check_main("h236", 3'b110, 2'd1, 4'd12, 1'b1);

        // Trigger seen on the very edge stage 1 would release (249).
        goto(246);
        trigger_in = 1'b1;
        goto(247);
        trigger_in = 1'b0;
        goto(248);
        check_main("o248", 3'b110, 2'd1, 4'd0, 1'b1);
        goto(249);
        check_main("o249", 3'b111, 2'd0, 4'd12, 1'b1);
        goto(250);
        check_main("o250", 3'b111, 2'd0, 4'd12, 1'b1);
        goto(263);
        check_main("o263", 3'b110, 2'd1, 4'd12, 1'b1);

        // Async reset between edges takes effect without a clock.
        goto(270);
        check_main("a270", 3'b110, 2'd1, 4'd5, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        check_main("async", 3'b111, 2'd0, 4'd12, 1'b1);
        check("async.r4", 32'(r4_out), 32'hF);
        @(posedge clk);
        #2;
        reset = 1'b0;
        cur_edge = 0;
        goto(13);
        check_main("r13", 3'b110, 2'd1, 4'd12, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
